// File: rtl/ws2812_pkg.sv
// ws2812_pkg
//  Shared definitions for the WS2812 frame transmitter:
//   - state_t     : frame FSM states
//   - COLOR_BITS  : bits per LED word (G,R,B x 8)
//   - DEF_*       : default timing for a 50MHz system clock
package ws2812_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PREP,
      SEND,
      LATCH
   } state_t;

   localparam int unsigned COLOR_BITS = 24;

   localparam int unsigned DEF_MAX_POS      = 16;
   localparam int unsigned DEF_T0H_CYCLES   = 18;    // 0.36us
   localparam int unsigned DEF_T1H_CYCLES   = 35;    // 0.70us
   localparam int unsigned DEF_BIT_CYCLES   = 63;    // 1.26us
   localparam int unsigned DEF_RESET_CYCLES = 15000; // 300us

endpackage

// File: rtl/ws2812_bit_encoder.sv
// ws2812_bit_encoder
//  Produces one WS2812 bit waveform per start request: data_out is high for T0H_CYCLES
//  ('0') or T1H_CYCLES ('1'), then low until BIT_CYCLES have elapsed. A start asserted in
//  the bit_last cycle chains the next bit with no gap.
// Ports
//  clk       in   system clock
//  reset_n   in   asynchronous active-low reset
//  start     in   begin a new bit on the next cycle
//  bit_val   in   value of the bit to send, sampled with start
//  data_out  out  registered serial data
//  bit_last  out  current cycle is the last one of the running bit period
module ws2812_bit_encoder
   import ws2812_pkg::*;
#(
   parameter int unsigned T0H_CYCLES = DEF_T0H_CYCLES,
   parameter int unsigned T1H_CYCLES = DEF_T1H_CYCLES,
   parameter int unsigned BIT_CYCLES = DEF_BIT_CYCLES
) (
   input  logic clk,
   input  logic reset_n,
   input  logic start,
   input  logic bit_val,
   output logic data_out,
   output logic bit_last
);

   localparam int unsigned CW = $clog2(BIT_CYCLES);
   localparam logic [CW-1:0] LAST_CNT = CW'(BIT_CYCLES - 1);
   localparam logic [CW-1:0] T0H      = CW'(T0H_CYCLES);
   localparam logic [CW-1:0] T1H      = CW'(T1H_CYCLES);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          bit_q, bit_d;
   logic          run_q, run_d;
   logic          data_q, data_d;
   logic [CW-1:0] high_len;

   assign high_len = bit_q ? T1H : T0H;
   assign bit_last = run_q && (cnt_q == LAST_CNT);
   assign data_out = data_q;

   // cnt_q is the cycle index within the bit that data_q currently shows, so the
   // output is computed one cycle ahead from the next index.
   always_comb begin
      cnt_d  = cnt_q;
      bit_d  = bit_q;
      run_d  = run_q;
      data_d = 1'b0;
      if (start) begin
         cnt_d  = '0;
         bit_d  = bit_val;
         run_d  = 1'b1;
         data_d = 1'b1;
      end else if (run_q) begin
         if (cnt_q == LAST_CNT) begin
            run_d = 1'b0;
         end else begin
            cnt_d  = cnt_q + 1'b1;
            data_d = (cnt_d < high_len);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q  <= '0;
         bit_q  <= 1'b0;
         run_q  <= 1'b0;
         data_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         bit_q  <= bit_d;
         run_q  <= run_d;
         data_q <= data_d;
      end
   end

endmodule

// File: rtl/ws2812_frame_transmitter.sv
// ws2812_frame_transmitter
//  Walks current_led over 0..MAX_POS-1, samples the GRB intensities returned by the
//  display unit and serialises each 24-bit word MSB first onto the WS2812 data line,
//  followed by a low latch period. Requests arriving while busy coalesce into one
//  pending frame that starts straight after the latch.
// Ports
//  clk                  in   system clock
//  reset_n              in   asynchronous active-low reset
//  update_frame         in   one-cycle frame request
//  led_green_intensity  in   G for the LED at current_led
//  led_red_intensity    in   R for the LED at current_led
//  led_blue_intensity   in   B for the LED at current_led
//  current_led          out  LED index presented to the display unit
//  busy                 out  frame in progress (PREP, SEND or LATCH)
//  frame_done           out  pulse in the last latch cycle
//  data_out             out  WS2812 serial data
module ws2812_frame_transmitter
   import ws2812_pkg::*;
#(
   parameter int unsigned MAX_POS      = DEF_MAX_POS,
   parameter int unsigned T0H_CYCLES   = DEF_T0H_CYCLES,
   parameter int unsigned T1H_CYCLES   = DEF_T1H_CYCLES,
   parameter int unsigned BIT_CYCLES   = DEF_BIT_CYCLES,
   parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       update_frame,
   input  logic [7:0]                 led_green_intensity,
   input  logic [7:0]                 led_red_intensity,
   input  logic [7:0]                 led_blue_intensity,
   output logic [$clog2(MAX_POS)-1:0] current_led,
   output logic                       busy,
   output logic                       frame_done,
   output logic                       data_out
);

   localparam int unsigned LW  = $clog2(MAX_POS);
   localparam int unsigned TW  = $clog2(RESET_CYCLES + 1);
   localparam int unsigned BW  = $clog2(COLOR_BITS);
   localparam int unsigned MSB = COLOR_BITS - 1;

   localparam logic [LW-1:0] LAST_LED   = LW'(MAX_POS - 1);
   localparam logic [TW-1:0] LATCH_LOAD = TW'(RESET_CYCLES - 1);
   localparam logic [BW-1:0] FIRST_BIT  = BW'(COLOR_BITS - 1);
   localparam logic [BW-1:0] BIT_ONE    = BW'(1);

   state_t                state_q, state_d;
   logic [COLOR_BITS-1:0] shreg_q, shreg_d;
   logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [LW-1:0]         led_q, led_d;
   logic [TW-1:0]         latch_q, latch_d;
   logic                  pending_q, pending_d;

   logic                  enc_start;
   logic                  enc_bit;
   logic                  bit_last;
   logic [COLOR_BITS-1:0] grb;

   assign grb         = {led_green_intensity, led_red_intensity, led_blue_intensity};
   assign current_led = led_q;
   assign busy        = (state_q != IDLE);

   ws2812_bit_encoder #(
      .T0H_CYCLES(T0H_CYCLES),
      .T1H_CYCLES(T1H_CYCLES),
      .BIT_CYCLES(BIT_CYCLES)
   ) u_bit_encoder (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (enc_start),
      .bit_val (enc_bit),
      .data_out(data_out),
      .bit_last(bit_last)
   );

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      bit_cnt_d  = bit_cnt_q;
      led_d      = led_q;
      latch_d    = latch_q;
      pending_d  = pending_q;
      enc_start  = 1'b0;
      enc_bit    = 1'b0;
      frame_done = 1'b0;

      if (update_frame && (state_q != IDLE)) begin
         pending_d = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            led_d = '0;
            if (update_frame) begin
               state_d = PREP;
            end
         end

         PREP: begin
            enc_start = 1'b1;
            enc_bit   = grb[MSB];
            shreg_d   = grb;
            bit_cnt_d = FIRST_BIT;
            state_d   = SEND;
         end

         SEND: begin
            if (bit_last) begin
               if (bit_cnt_q != '0) begin
                  // Rotate rather than shift; the wrapped bits are never sent.
                  enc_start = 1'b1;
                  enc_bit   = shreg_q[MSB-1];
                  shreg_d   = {shreg_q[MSB-1:0], shreg_q[MSB]};
                  bit_cnt_d = bit_cnt_q - 1'b1;
                  // Advance the index as bit 0 begins so the display unit has a whole
                  // bit period to settle before the reload.
                  if (bit_cnt_q == BIT_ONE) begin
                     if (led_q == LAST_LED) begin
                        led_d = '0;
                     end else begin
                        led_d = led_q + 1'b1;
                     end
                  end
               end else if (led_q == '0) begin
                  // Index already wrapped: the word just sent belonged to the last LED.
                  state_d = LATCH;
                  latch_d = LATCH_LOAD;
               end else begin
                  enc_start = 1'b1;
                  enc_bit   = grb[MSB];
                  shreg_d   = grb;
                  bit_cnt_d = FIRST_BIT;
               end
            end
         end

         LATCH: begin
            if (latch_q == '0) begin
               frame_done = 1'b1;
               // A request landing in this very cycle still earns a follow-on frame.
               if (pending_q || update_frame) begin
                  state_d   = PREP;
                  pending_d = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               latch_d = latch_q - 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         led_q     <= '0;
         latch_q   <= '0;
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         led_q     <= led_d;
         latch_q   <= latch_d;
         pending_q <= pending_d;
      end
   end

endmodule

// File: tb/tb_ws2812_frame_transmitter.sv
// tb_ws2812_frame_transmitter
//  Drives two transmitter instances (4 and 5 LEDs, shortened latch time) and decodes
//  the serial line back into high times, bit periods and GRB words, comparing them with
//  the intensity tables the bench presents to the DUT.
module tb_ws2812_frame_transmitter;

   localparam int T0H  = 18;
   localparam int T1H  = 35;
   localparam int BITC = 63;
   localparam int RST  = 150;
   localparam int ABORT_N = 2 + (2 * 24 + 10) * BITC + 5;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic upd = 1'b0;
   logic sel5 = 1'b0;

   logic [7:0] tg [0:7];
   logic [7:0] tr [0:7];
   logic [7:0] tbl [0:7];

   logic       upd4, upd5;
   logic [7:0] g4, r4, b4, g5, r5, b5;
   logic [1:0] cur4;
   logic [2:0] cur5;
   logic       busy4, done4, d4, busy5, done5, d5;
   logic       mon_d, mon_done, mon_busy;
   logic [2:0] mon_cur;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   assign upd4 = upd & ~sel5;
   assign upd5 = upd & sel5;
   assign g4 = tg[{1'b0, cur4}];
   assign r4 = tr[{1'b0, cur4}];
   assign b4 = tbl[{1'b0, cur4}];
   assign g5 = tg[cur5];
   assign r5 = tr[cur5];
   assign b5 = tbl[cur5];

   assign mon_d    = sel5 ? d5 : d4;
   assign mon_done = sel5 ? done5 : done4;
   assign mon_busy = sel5 ? busy5 : busy4;
   assign mon_cur  = sel5 ? cur5 : {1'b0, cur4};

   ws2812_frame_transmitter #(
      .MAX_POS(4), .T0H_CYCLES(T0H), .T1H_CYCLES(T1H), .BIT_CYCLES(BITC), .RESET_CYCLES(RST)
   ) dut4 (
      .clk(clk), .reset_n(reset_n), .update_frame(upd4),
      .led_green_intensity(g4), .led_red_intensity(r4), .led_blue_intensity(b4),
      .current_led(cur4), .busy(busy4), .frame_done(done4), .data_out(d4)
   );

   ws2812_frame_transmitter #(
      .MAX_POS(5), .T0H_CYCLES(T0H), .T1H_CYCLES(T1H), .BIT_CYCLES(BITC), .RESET_CYCLES(RST)
   ) dut5 (
      .clk(clk), .reset_n(reset_n), .update_frame(upd5),
      .led_green_intensity(g5), .led_red_intensity(r5), .led_blue_intensity(b5),
      .current_led(cur5), .busy(busy5), .frame_done(done5), .data_out(d5)
   );

   // Line decoder: each bit is a high run followed by a low run. A low run reaching 100
   // cycles (longer than any bit, shorter than the latch) closes a burst, marked by -1.
   int   hi_q[$];
   int   lo_q[$];
   int   hi = 0;
   int   lo_run = 0;
   int   done_lo = 0;
   logic prev_d = 1'b0;

   always @(negedge clk) begin
      if (mon_d === 1'b1) begin
         if (prev_d !== 1'b1 && hi != 0) begin
            hi_q.push_back(hi);
            lo_q.push_back(lo_run);
            hi = 0;
         end
         hi++;
         lo_run = 0;
      end else begin
         lo_run++;
         if (hi != 0 && lo_run == 100) begin
            hi_q.push_back(hi);
            lo_q.push_back(-1);
            hi = 0;
         end
      end
      if (mon_done === 1'b1) done_lo = lo_run;
      prev_d = mon_d;
   end

   function automatic int frame_len(input int nleds);
      return 1 + nleds * 24 * BITC + RST;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic kick();
      @(negedge clk);
      upd = 1'b1;
      @(negedge clk);
      upd = 1'b0;
   endtask

   int led_seq[$];

   // Called in the PREP cycle; returns in the frame_done cycle (or after the budget).
   task automatic run_frame(input string tag, input int nleds, input int pa, input int pb,
                            input int pc, input bit pulse_done);
      int n = 1;
      bit found = 1'b0;
      int busy_low = 0;
      int lim = frame_len(nleds) + 20;
      led_seq.delete();
      led_seq.push_back(int'(mon_cur));
      while (!found && n <= lim) begin
         if (mon_busy !== 1'b1) busy_low++;
         if (int'(mon_cur) != led_seq[$]) led_seq.push_back(int'(mon_cur));
         if (mon_done === 1'b1) begin
            found = 1'b1;
            upd = pulse_done;
         end else begin
            upd = (n == pa || n == pb || n == pc);
            @(negedge clk);
            n++;
         end
      end
      check({tag, "_done_seen"}, found, 1);
      check({tag, "_latency"}, n, frame_len(nleds));
      check({tag, "_busy_held"}, busy_low, 0);
   endtask

   task automatic analyze(input string tag, input int nleds, input int exp_hi);
      int nb, bad_hi, bad_exp, bad_per, bad_word, max_lo, last_hi, last_lo, idx;
      logic [23:0] w;
      #2;
      nb = hi_q.size();
      bad_hi = 0; bad_exp = 0; bad_per = 0; bad_word = 0; max_lo = 0;
      last_hi = (nb > 0) ? hi_q[nb-1] : 0;
      last_lo = (nb > 0) ? lo_q[nb-1] : 0;
      for (int k = 0; k < nb; k++) begin
         if (hi_q[k] != T0H && hi_q[k] != T1H) bad_hi++;
         if (exp_hi != 0 && hi_q[k] != exp_hi) bad_exp++;
      end
      for (int k = 0; k < nb - 1; k++) begin
         if (hi_q[k] + lo_q[k] != BITC) bad_per++;
         if (lo_q[k] > max_lo) max_lo = lo_q[k];
      end
      for (int i = 0; i < nleds; i++) begin
         w = '0;
         for (int j = 0; j < 24; j++) begin
            idx = i * 24 + j;
            w = {w[22:0], (idx < nb) && (hi_q[idx] == T1H)};
         end
         if (w !== {tg[i], tr[i], tbl[i]}) bad_word++;
      end
      check({tag, "_nbits"}, nb, nleds * 24);
      check({tag, "_high_time"}, bad_hi, 0);
      check({tag, "_high_exact"}, bad_exp, 0);
      check({tag, "_period"}, bad_per, 0);
      check({tag, "_max_gap"}, max_lo <= BITC - T0H, 1);
      check({tag, "_burst_end"}, last_lo, -1);
      check({tag, "_words"}, bad_word, 0);
      check({tag, "_latch_low"}, done_lo, BITC - last_hi + RST);
      hi_q.delete();
      lo_q.delete();
   endtask

   task automatic rand_tables();
      for (int i = 0; i < 8; i++) begin
         tg[i]  = 8'($urandom_range(0, 255));
         tr[i]  = 8'($urandom_range(0, 255));
         tbl[i] = 8'($urandom_range(0, 255));
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         tg[i] = 8'h00; tr[i] = 8'h00; tbl[i] = 8'h00;
      end
      repeat (3) @(negedge clk);
      check("rst_data4", d4, 0);
      check("rst_busy4", busy4, 0);
      check("rst_done4", done4, 0);
      check("rst_led4", cur4, 0);
      check("rst_data5", d5, 0);
      check("rst_busy5", busy5, 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Constant colour on every LED
      for (int i = 0; i < 8; i++) begin
         tg[i] = 8'hA5; tr[i] = 8'h0F; tbl[i] = 8'h81;
      end
      kick();
      run_frame("t1", 4, 0, 0, 0, 1'b0);
      analyze("t1", 4, 0);
      @(negedge clk);
      check("t1_idle_after", busy4, 0);

      // Colour as a function of the LED index
      for (int i = 0; i < 8; i++) begin
         tg[i] = 8'(i); tr[i] = ~8'(i); tbl[i] = 8'(i << 4);
      end
      kick();
      run_frame("t2", 4, 0, 0, 0, 1'b0);
      check("t2_led_steps", led_seq.size(), 5);
      for (int i = 0; i < 5; i++) check("t2_led_seq", led_seq[i], i % 4);
      analyze("t2", 4, 0);

      // Coalesced requests: three mid-frame and one in the frame_done cycle
      rand_tables();
      kick();
      run_frame("t3a", 4, 500, 1500, 2500, 1'b1);
      analyze("t3a", 4, 0);
      @(negedge clk);
      upd = 1'b0;
      check("t3_prep_busy", busy4, 1);
      run_frame("t3b", 4, 0, 0, 0, 1'b0);
      analyze("t3b", 4, 0);
      @(negedge clk);
      check("t3_idle_after", busy4, 0);
      repeat (200) @(negedge clk);
      check("t3_no_third", hi_q.size(), 0);
      check("t3_still_idle", busy4, 0);

      // Asynchronous reset during bit 10 of LED 2
      rand_tables();
      kick();
      repeat (ABORT_N - 1) @(negedge clk);
      check("t4_pre_data", d4, 1);
      check("t4_pre_led", cur4, 2);
      reset_n = 1'b0;
      #1;
      check("t4_rst_data", d4, 0);
      check("t4_rst_busy", busy4, 0);
      check("t4_rst_led", cur4, 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (150) @(negedge clk);
      check("t4_idle_after_rst", busy4, 0);
      hi_q.delete();
      lo_q.delete();
      rand_tables();
      kick();
      run_frame("t4", 4, 0, 0, 0, 1'b0);
      check("t4_restart_led0", led_seq[0], 0);
      analyze("t4", 4, 0);

      // All-zero and all-ones intensities
      for (int i = 0; i < 8; i++) begin
         tg[i] = 8'h00; tr[i] = 8'h00; tbl[i] = 8'h00;
      end
      kick();
      run_frame("t5z", 4, 0, 0, 0, 1'b0);
      analyze("t5z", 4, T0H);
      for (int i = 0; i < 8; i++) begin
         tg[i] = 8'hFF; tr[i] = 8'hFF; tbl[i] = 8'hFF;
      end
      kick();
      run_frame("t5f", 4, 0, 0, 0, 1'b0);
      analyze("t5f", 4, T1H);

      // Non-power-of-two strip length
      @(negedge clk);
      sel5 = 1'b1;
      rand_tables();
      kick();
      run_frame("t6", 5, 0, 0, 0, 1'b0);
      check("t6_led_steps", led_seq.size(), 6);
      for (int i = 0; i < 6; i++) check("t6_led_seq", led_seq[i], i % 5);
      analyze("t6", 5, 0);
      @(negedge clk);
      check("t6_idle_after", busy5, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
